mem_access_unit: RTL and testbench

MEM-stage data-memory access unit. Consumes the EX/MEM pipeline register outputs (ALU result as address, rs2 data, read/write code, memory select) and drives a req/ready + rvalid data-memory bus. Stalls the pipeline until the access completes, then delivers aligned, sign/zero-extended load data to the MEM/WB path. Detects misaligned and illegal accesses.

---
 rtl/mem_pkg.sv | 34 +++
 rtl/load_align.sv | 33 +++
 rtl/mem_access_unit.sv | 171 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage data-memory access unit.
package mem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDone
  } mem_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned RW_STORE_BIT = 3;

  // True when funct3 is a legal load/store encoding and the offset is naturally aligned.
  function automatic logic access_legal(input logic we, input logic [2:0] f3,
                                        input logic [1:0] off);
    logic ok;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~off[0];
      F3_W:    ok = (off == 2'b00);
      F3_BU:   ok = ~we;
      F3_HU:   ok = ~we & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load lane select and sign/zero extension of a 32-bit read word.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Pick the addressed lane, then extend according to funct3.
  always_comb begin
    unique case (off)
      2'd0: byte_lane = rdata[7:0];
      2'd1: byte_lane = rdata[15:8];
      2'd2: byte_lane = rdata[23:16];
      2'd3: byte_lane = rdata[31:24];
      default: byte_lane = rdata[7:0];
    endcase
    half_lane = off[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    result = {{24{byte_lane[7]}}, byte_lane};
      F3_H:    result = {{16{half_lane[15]}}, half_lane};
      F3_BU:   result = {24'h0, byte_lane};
      F3_HU:   result = {16'h0, half_lane};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: req/ready + rvalid bus master with pipeline stall.
// Optional bus timeout enabled by defining MEM_ACCESS_TIMEOUT_EN.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] EX_ADDR,
  input  logic [31:0] EX_DATA2,
  input  logic [3:0]  EX_READ_WRITE,
  input  logic        EX_DATAMEMSEL,
  output logic        STALL,
  output logic [31:0] LOAD_DATA,
  output logic        LOAD_VALID,
  output logic        ACCESS_FAULT,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  output logic [3:0]  MEM_BE,
  input  logic        MEM_READY,
  input  logic        MEM_RVALID,
  input  logic [31:0] MEM_RDATA
);

  mem_state_e  state_q, state_d;
  logic [31:0] addr_q, wdata_q, load_data_q;
  logic [3:0]  be_q;
  logic        we_q, fault_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;

  logic        ex_we;
  logic [2:0]  ex_f3;
  logic [1:0]  ex_off;
  logic        start, illegal_req;
  logic [31:0] st_wdata, aligned;
  logic [3:0]  st_be;
  logic        timeout_hit, timed_out, to_set;

  assign ex_we       = EX_READ_WRITE[RW_STORE_BIT];
  assign ex_f3       = EX_READ_WRITE[2:0];
  assign ex_off      = EX_ADDR[1:0];
  assign start       = (state_q == StIdle) & EX_DATAMEMSEL & access_legal(ex_we, ex_f3, ex_off);
  assign illegal_req = (state_q == StIdle) & EX_DATAMEMSEL & ~access_legal(ex_we, ex_f3, ex_off);

  // Store byte enables and lane-replicated write data; loads read the whole word.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = EX_DATA2;
    if (ex_we) begin
      case (ex_f3)
        F3_B: begin
          st_be    = 4'b0001 << ex_off;
          st_wdata = {4{EX_DATA2[7:0]}};
        end
        F3_H: begin
          st_be    = 4'b0011 << {ex_off[1], 1'b0};
          st_wdata = {2{EX_DATA2[15:0]}};
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES < 255) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q;
  logic            to_q;

  // cnt_q counts completed REQ/WAIT cycles, so this fires in the last allowed cycle.
  assign timeout_hit = ((state_q == StReq) || (state_q == StWait)) &&
                       ((32'(cnt_q) + 32'd1) >= TIMEOUT_CYCLES);
  assign timed_out   = to_q;

  // Bus wait counter and sticky timeout flag for the current access.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      if (start) begin
        cnt_q <= '0;
        to_q  <= 1'b0;
      end else begin
        if ((state_q == StReq) || (state_q == StWait)) cnt_q <= cnt_q + CntW'(1);
        if (to_set) to_q <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout_cfg;
  assign timeout_hit        = 1'b0;
  assign timed_out          = 1'b0;
  assign unused_timeout_cfg = ^{TIMEOUT_CYCLES, to_set};
`endif

  // Next-state logic; bus completion has priority over a simultaneous timeout.
  always_comb begin
    state_d = state_q;
    to_set  = 1'b0;
    unique case (state_q)
      StIdle: if (start) state_d = StReq;
      StReq: begin
        if (MEM_READY) begin
          state_d = we_q ? StDone : StWait;
        end else if (timeout_hit) begin
          state_d = StDone;
          to_set  = 1'b1;
        end
      end
      StWait: begin
        if (MEM_RVALID) begin
          state_d = StDone;
        end else if (timeout_hit) begin
          state_d = StDone;
          to_set  = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, latched request fields, fault pulse and load result.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      we_q        <= 1'b0;
      off_q       <= '0;
      f3_q        <= '0;
      fault_q     <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q <= state_d;
      fault_q <= illegal_req;
      if (start) begin
        addr_q  <= {EX_ADDR[31:2], 2'b00};
        wdata_q <= st_wdata;
        be_q    <= st_be;
        we_q    <= ex_we;
        off_q   <= ex_off;
        f3_q    <= ex_f3;
      end
      if ((state_q == StWait) && MEM_RVALID) load_data_q <= aligned;
    end
  end

  load_align u_load_align (
    .rdata  (MEM_RDATA),
    .off    (off_q),
    .funct3 (f3_q),
    .result (aligned)
  );

  assign STALL        = start | (state_q == StReq) | (state_q == StWait);
  assign MEM_REQ      = (state_q == StReq);
  assign MEM_WE       = we_q;
  assign MEM_ADDR     = addr_q;
  assign MEM_WDATA    = wdata_q;
  assign MEM_BE       = be_q;
  assign LOAD_DATA    = load_data_q;
  assign LOAD_VALID   = (state_q == StDone) & ~we_q & ~timed_out;
  assign ACCESS_FAULT = fault_q | ((state_q == StDone) & timed_out);

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a behavioural access model.
module tb_mem_access_unit;

  localparam int unsigned TO = 8;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [31:0] EX_ADDR, EX_DATA2, LOAD_DATA, MEM_ADDR, MEM_WDATA, MEM_RDATA;
  logic [3:0]  EX_READ_WRITE, MEM_BE;
  logic        EX_DATAMEMSEL, STALL, LOAD_VALID, ACCESS_FAULT, MEM_REQ, MEM_WE;
  logic        MEM_READY, MEM_RVALID;

  int total = 0;
  int bad   = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST_N(RST_N), .EX_ADDR(EX_ADDR), .EX_DATA2(EX_DATA2),
    .EX_READ_WRITE(EX_READ_WRITE), .EX_DATAMEMSEL(EX_DATAMEMSEL), .STALL(STALL),
    .LOAD_DATA(LOAD_DATA), .LOAD_VALID(LOAD_VALID), .ACCESS_FAULT(ACCESS_FAULT),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_BE(MEM_BE), .MEM_READY(MEM_READY), .MEM_RVALID(MEM_RVALID), .MEM_RDATA(MEM_RDATA)
  );

  always #5 CLK = ~CLK;

  // Observations of one access, filled by run_access.
  int          o_stall, o_req, o_lv, o_fault, o_lv_k;
  logic        o_ended, o_unstable, o_seen_req, o_we;
  logic [31:0] o_addr, o_wdata, o_ld, o_ld_after;
  logic [3:0]  o_be;
  logic [31:0] last_load;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Reference model: legality from access size and alignment.
  function automatic logic m_legal(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int size;
    if (we && f3 > 3'd2) return 1'b0;
    if (!we && (f3 == 3'd3 || f3 > 3'd5)) return 1'b0;
    size = 1 << f3[1:0];
    return (int'(a[1:0]) % size) == 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off,
                                         input logic [31:0] rdata);
    logic [31:0] w;
    w = rdata >> (8 * off);
    case (f3)
      3'd0:    return {{24{w[7]}}, w[7:0]};
      3'd1:    return {{16{w[15]}}, w[15:0]};
      3'd4:    return {24'h0, w[7:0]};
      3'd5:    return {16'h0, w[15:0]};
      default: return rdata;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic we, input logic [2:0] f3, input logic [1:0] off);
    if (!we) return 4'hF;
    if (f3 == 3'd0) return 4'b0001 << off;
    if (f3 == 3'd1) return 4'b0011 << off;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 3'd0) return {4{d[7:0]}};
    if (f3 == 3'd1) return {2{d[15:0]}};
    return d;
  endfunction

  // Drives one access and acts as the bus slave; records what the DUT did.
  task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] data2, input logic [31:0] rdata,
                            input int rw, input int vw, input logic junk);
    int   req_cnt = 0;
    int   wait_cnt = 0;
    logic handshake = 1'b0;
    logic rv_done = 1'b0;
    o_stall = 0; o_req = 0; o_lv = 0; o_fault = 0; o_lv_k = -1;
    o_ended = 1'b0; o_unstable = 1'b0; o_seen_req = 1'b0; o_ld = 'x;
    step();
    EX_ADDR = addr; EX_DATA2 = data2; EX_READ_WRITE = {we, f3}; EX_DATAMEMSEL = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (k == 1) EX_DATAMEMSEL = 1'b0;
      MEM_READY  = MEM_REQ && (req_cnt == rw);
      MEM_RVALID = 1'b0;
      MEM_RDATA  = $urandom;
      if (handshake && !we && !rv_done && wait_cnt == vw) begin
        MEM_RVALID = 1'b1;
        MEM_RDATA  = rdata;
      end else if (junk && MEM_REQ) begin
        MEM_RVALID = 1'b1;
      end
      #1;
      if (STALL) o_stall++;
      if (MEM_REQ) begin
        if (!o_seen_req) begin
          o_seen_req = 1'b1;
          o_addr = MEM_ADDR; o_wdata = MEM_WDATA; o_be = MEM_BE; o_we = MEM_WE;
        end else if (o_addr !== MEM_ADDR || o_wdata !== MEM_WDATA || o_be !== MEM_BE ||
                     o_we !== MEM_WE) begin
          o_unstable = 1'b1;
        end
        o_req++;
      end
      if (LOAD_VALID) begin
        o_lv++;
        o_lv_k = k;
        o_ld   = LOAD_DATA;
      end
      if (ACCESS_FAULT) o_fault++;
      if (handshake && !rv_done) begin
        if (MEM_RVALID) rv_done = 1'b1;
        else wait_cnt++;
      end
      if (MEM_REQ) begin
        if (MEM_READY) handshake = 1'b1;
        else req_cnt++;
      end
      if (k >= 1 && !STALL) begin
        o_ended = 1'b1;
        break;
      end
      step();
    end
    // One trailing idle cycle to confirm pulses are single-cycle.
    step();
    EX_DATAMEMSEL = 1'b0; MEM_READY = 1'b0; MEM_RVALID = 1'b0;
    #1;
    if (LOAD_VALID) o_lv++;
    if (ACCESS_FAULT) o_fault++;
    if (MEM_REQ) o_req++;
    if (STALL) o_stall++;
    o_ld_after = LOAD_DATA;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    EX_ADDR = '0; EX_DATA2 = '0; EX_READ_WRITE = '0; EX_DATAMEMSEL = 1'b0;
    MEM_READY = 1'b0; MEM_RVALID = 1'b0; MEM_RDATA = '0;
    #12;
    total++;
    if ({STALL, MEM_REQ, MEM_WE, LOAD_VALID, ACCESS_FAULT} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {STALL, MEM_REQ, MEM_WE, LOAD_VALID, ACCESS_FAULT});
    end
    total++;
    if (MEM_ADDR !== 32'h0 || MEM_WDATA !== 32'h0) begin
      bad++;
      $display("FAIL reset_bus: got addr=%h wdata=%h want 0", MEM_ADDR, MEM_WDATA);
    end
    total++;
    if (LOAD_DATA !== 32'h0 || MEM_BE !== 4'h0) begin
      bad++;
      $display("FAIL reset_load: got ld=%h be=%b want 0", LOAD_DATA, MEM_BE);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    last_load = 32'h0;
  endtask

  task automatic test_load_word();
    run_access(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 1'b0);
    last_load = 32'hDEADBEEF;
    total++;
    if (!o_ended || o_addr !== 32'h100 || o_be !== 4'hF || o_we !== 1'b0) begin
      bad++;
      $display("FAIL lw_bus: got end=%b addr=%h be=%b we=%b want 1 100 1111 0",
               o_ended, o_addr, o_be, o_we);
    end
    total++;
    if (o_stall != 3 || o_lv_k != 3 || o_lv != 1) begin
      bad++;
      $display("FAIL lw_timing: got stall=%0d lv_k=%0d lv=%0d want 3 3 1", o_stall, o_lv_k, o_lv);
    end
    total++;
    if (o_ld !== 32'hDEADBEEF || o_ld_after !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL lw_data: got %h/%h want deadbeef", o_ld, o_ld_after);
    end
  endtask

  task automatic test_load_byte();
    run_access(1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_0000, 0, 0, 1'b0);
    total++;
    if (o_ld !== 32'hFFFFFF80 || o_addr !== 32'h100) begin
      bad++;
      $display("FAIL lb_sign: got ld=%h addr=%h want ffffff80 100", o_ld, o_addr);
    end
    run_access(1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF_0000, 1, 2, 1'b1);
    last_load = 32'h80;
    total++;
    if (o_ld !== 32'h00000080 || o_stall != 6) begin
      bad++;
      $display("FAIL lbu_zero: got ld=%h stall=%0d want 00000080 6", o_ld, o_stall);
    end
  endtask

  task automatic test_store_half();
    run_access(1'b1, 3'd1, 32'h202, 32'h1234ABCD, 32'h0, 3, 0, 1'b1);
    total++;
    if (o_wdata !== 32'hABCDABCD || o_be !== 4'b1100 || o_we !== 1'b1 || o_addr !== 32'h200) begin
      bad++;
      $display("FAIL sh_bus: got wd=%h be=%b we=%b addr=%h want abcdabcd 1100 1 200",
               o_wdata, o_be, o_we, o_addr);
    end
    total++;
    if (o_req != 4 || o_lv != 0 || o_stall != 5 || o_unstable) begin
      bad++;
      $display("FAIL sh_flow: got req=%0d lv=%0d stall=%0d unstable=%b want 4 0 5 0",
               o_req, o_lv, o_stall, o_unstable);
    end
    total++;
    if (o_ld_after !== last_load) begin
      bad++;
      $display("FAIL sh_hold: got ld=%h want %h", o_ld_after, last_load);
    end
  endtask

  task automatic test_faults();
    logic [3:0]  rw_codes [3] = '{4'b0010, 4'b0011, 4'b1100};
    logic [31:0] addrs [3] = '{32'h101, 32'h100, 32'h104};
    for (int i = 0; i < 3; i++) begin
      run_access(rw_codes[i][3], rw_codes[i][2:0], addrs[i], 32'h0, 32'h0, 0, 0, 1'b0);
      total++;
      if (o_fault != 1 || o_req != 0 || o_stall != 0 || o_lv != 0 || !o_ended) begin
        bad++;
        $display("FAIL fault_%0d: got fault=%0d req=%0d stall=%0d lv=%0d want 1 0 0 0",
                 i, o_fault, o_req, o_stall, o_lv);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lv_seen = 0;
    step();
    EX_ADDR = 32'h40; EX_READ_WRITE = 4'b0010; EX_DATAMEMSEL = 1'b1;
    step();
    EX_DATAMEMSEL = 1'b0;
    MEM_READY = 1'b1;
    step();
    MEM_READY = 1'b0;
    #1;
    total++;
    if (MEM_REQ !== 1'b0 || STALL !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_wait: got req=%b stall=%b want 0 1", MEM_REQ, STALL);
    end
    RST_N = 1'b0;
    #1;
    total++;
    if (MEM_REQ !== 1'b0 || STALL !== 1'b0 || LOAD_VALID !== 1'b0 || ACCESS_FAULT !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_idle: got req=%b stall=%b lv=%b af=%b want 0000",
               MEM_REQ, STALL, LOAD_VALID, ACCESS_FAULT);
    end
    step();
    RST_N = 1'b1;
    MEM_RVALID = 1'b1;
    MEM_RDATA = 32'h5555_AAAA;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (LOAD_VALID || STALL || MEM_REQ) lv_seen++;
      step();
    end
    MEM_RVALID = 1'b0;
    last_load = 32'h0;
    total++;
    if (lv_seen != 0 || LOAD_DATA !== 32'h0) begin
      bad++;
      $display("FAIL rst_mid_stale: got activity=%0d ld=%h want 0 0", lv_seen, LOAD_DATA);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic        we, legal;
      logic [2:0]  f3;
      logic [31:0] addr, d2, rd;
      int          rw, vw, exp_stall;
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      addr = $urandom; d2 = $urandom; rd = $urandom;
      rw = $urandom_range(0, 2);
      vw = $urandom_range(0, 2);
      legal = m_legal(we, f3, addr);
      run_access(we, f3, addr, d2, rd, rw, vw, 1'($urandom_range(0, 1)));
      if (!legal) exp_stall = 0;
      else if (we) exp_stall = rw + 2;
      else exp_stall = rw + vw + 3;
      if (legal && !we) last_load = m_load(f3, addr[1:0], rd);
      total++;
      if (!o_ended || o_stall != exp_stall || o_fault != (legal ? 0 : 1) ||
          o_req != (legal ? rw + 1 : 0) || o_lv != ((legal && !we) ? 1 : 0)) begin
        bad++;
        $display("FAIL rnd_flow[%0d]: got end=%b stall=%0d fault=%0d req=%0d lv=%0d want stall=%0d legal=%b we=%b rw=%0d",
                 i, o_ended, o_stall, o_fault, o_req, o_lv, exp_stall, legal, we, rw);
      end
      if (legal) begin
        total++;
        if (o_addr !== {addr[31:2], 2'b00} || o_be !== m_be(we, f3, addr[1:0]) ||
            o_we !== we || o_unstable || (we && o_wdata !== m_wdata(f3, d2))) begin
          bad++;
          $display("FAIL rnd_bus[%0d]: got addr=%h be=%b we=%b wd=%h unstable=%b want addr=%h be=%b",
                   i, o_addr, o_be, o_we, o_wdata, o_unstable, {addr[31:2], 2'b00},
                   m_be(we, f3, addr[1:0]));
        end
      end
      if (legal && !we) begin
        total++;
        if (o_ld !== last_load || o_lv_k != exp_stall) begin
          bad++;
          $display("FAIL rnd_load[%0d]: got ld=%h k=%0d want ld=%h k=%0d",
                   i, o_ld, o_lv_k, last_load, exp_stall);
        end
      end
      total++;
      if (o_ld_after !== last_load) begin
        bad++;
        $display("FAIL rnd_hold[%0d]: got ld=%h want %h", i, o_ld_after, last_load);
      end
    end
  endtask

`ifdef MEM_ACCESS_TIMEOUT_EN
  task automatic test_timeout();
    run_access(1'b0, 3'd2, 32'h300, 32'h0, 32'h0, 1000, 0, 1'b0);
    total++;
    if (!o_ended || o_req != TO || o_stall != TO + 1 || o_fault != 1 || o_lv != 0 ||
        o_ld_after !== last_load) begin
      bad++;
      $display("FAIL timeout: got end=%b req=%0d stall=%0d fault=%0d lv=%0d ld=%h want req=%0d",
               o_ended, o_req, o_stall, o_fault, o_lv, o_ld_after, TO);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_word();
    test_load_byte();
    test_store_half();
    test_faults();
    test_reset_mid();
    test_random();
`ifdef MEM_ACCESS_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
